mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the CPU datapath and the word-only data memory. Accepts byte, halfword and word load/store requests. Drives the memory's word-aligned rd/wr port: combinational read data, write committed on the clock edge. Synthesises sub-word stores by read-modify-write, sign- or zero-extends sub-word loads, and flags misaligned accesses without touching memory.

## Interface
- BIG_ENDIAN, 0, byte-lane order. 0: byte k at bits [8k+7:8k]. 1: byte k at bits [31-8k:24-8k]. Halfword lanes follow the same rule.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors; held until the next response
- resp_err  out  1  misaligned access; valid with resp_valid
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_wdata  out  32  memory write word
- mem_rdata  in  32  memory read word; combinational, same cycle as mem_rd/mem_addr

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- Handshake: accept on an edge with req_valid & req_ready. The request is registered: op, byte offset, and wdata. mem_addr <= {req_addr[31:2],2'b00}.
- Alignment: LW/SW require addr[1:0]=0. LH/LHU/SH require addr[0]=0. Bytes are always aligned.
- Misaligned request, on the accept edge:
  - resp_valid<=1, resp_err<=1, resp_rdata<=0.
  - State stays IDLE. No memory cycle is issued.
- Aligned request, on the accept edge:
  - LW/LH/LHU/LB/LBU -> LOAD.
  - SW -> STORE.
  - SH/SB -> RMW_RD.
- LOAD: mem_rd=1. On the edge:
  - resp_rdata <= extracted lane, sign-extended for LH/LB, zero-extended for LHU/LBU.
  - resp_valid<=1. State -> IDLE.
- STORE: mem_wr=1, mem_wdata=stored word. On the edge, memory writes, resp_valid<=1, state -> IDLE.
- RMW_RD: mem_rd=1. On the edge, the merge register <= mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0]. State -> RMW_WR.
- RMW_WR: mem_wr=1, mem_wdata=merge register. On the edge, memory writes, resp_valid<=1, resp_rdata<=0, state -> IDLE.
- mem_rd and mem_wr are decoded combinationally from state. Both are 0 in IDLE. They are never both 1.
- resp_err<=0 on every non-error response.

## Timing
- Reset (asserted, asynchronous):
  - State IDLE. req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Merge register=0.
- Latency, counted in edges from the accept edge to the edge that raises resp_valid:
  - Misaligned: 0. resp_valid is high in the cycle right after accept.
  - LW/LH/LHU/LB/LBU/SW: 1.
  - SH/SB: 2.
- Throughput: req_ready returns high in the same cycle resp_valid is high, so the next request can be accepted then. A continuous LW stream completes one access per 2 cycles.
- Requests presented while req_ready=0 are ignored. The requester holds them.
- Reset mid-operation:
  - The state drops to IDLE immediately, so mem_wr falls combinationally.
  - A write in RMW_WR or STORE whose edge has not yet occurred is not performed.
  - No response is produced for the aborted request.
- Memory contents are unchanged by RMW except the addressed lane. The read and the write of an RMW use the same registered mem_addr.

## Test plan
- Word 0x10 preloaded 0x8899AABB, BIG_ENDIAN=0. Check for each request:
  - LW 0x10 -> 0x8899AABB, err=0, resp 2 cycles after accept.
  - LB 0x11 -> 0xFFFFFFAA.
  - LBU 0x11 -> 0x000000AA.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
- Same preload: SB 0x13 wdata 0x12345677 -> one mem_rd cycle, then one mem_wr cycle with mem_wdata 0x7799AABB. A following LW 0x10 returns 0x7799AABB.
- Same preload: SH 0x10 wdata 0xDEADBEEF -> memory 0x8899BEEF. Repeat with BIG_ENDIAN=1 -> memory 0xBEEFAABB.
- Misaligned LW 0x16, LH 0x13, SW 0x11 -> each gives resp_valid+resp_err the cycle after accept, resp_rdata=0, with mem_rd=mem_wr=0 throughout and memory unchanged.
- Back-to-back: req_valid held high with LW 0x0, 0x4, 0x8 -> three responses, accepts every 2 cycles, correct data, no dropped or duplicated responses.
- Assert reset during RMW_WR of SB 0x10 -> mem_wr falls immediately, word 0x10 unchanged, no resp_valid, and all outputs at their reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory. Sub-word loads are extracted
// and extended; sub-word stores become a read-modify-write of the containing word.
module mem_access_unit #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned DW = 32;
   localparam int unsigned HW = 16;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   state_t          state;
   logic [2:0]      op_q;
   logic [1:0]      off_q;
   logic [HW-1:0]   wdata_q;

   logic            misaligned_c;
   logic            is_load_c;
   logic [1:0]      blane_c;
   logic            hlane_c;
   logic [7:0]      ld_byte_c;
   logic [HW-1:0]   ld_half_c;
   logic [DW-1:0]   ld_data_c;
   logic [DW-1:0]   rmw_data_c;

   assign req_ready = (state == IDLE);
   assign mem_rd    = (state == LOAD)  || (state == RMW_RD);
   assign mem_wr    = (state == STORE) || (state == RMW_WR);

   // Alignment rules: words need offset 0, halfwords an even offset
   always_comb begin
      misaligned_c = 1'b0;
      case (req_op)
         OP_LW, OP_SW:         misaligned_c = (req_addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: misaligned_c = req_addr[0];
         default:              misaligned_c = 1'b0;
      endcase
   end

   assign is_load_c = (req_op < OP_SW);

   // Physical lane holding the addressed byte / halfword
   assign blane_c = BIG_ENDIAN ? 2'(2'd3 - off_q) : off_q;
   assign hlane_c = BIG_ENDIAN ? ~off_q[1] : off_q[1];

   always_comb begin
      ld_byte_c = 8'h00;
      case (blane_c)
         2'd0:    ld_byte_c = mem_rdata[7:0];
         2'd1:    ld_byte_c = mem_rdata[15:8];
         2'd2:    ld_byte_c = mem_rdata[23:16];
         default: ld_byte_c = mem_rdata[31:24];
      endcase
      ld_half_c = hlane_c ? mem_rdata[31:16] : mem_rdata[15:0];

      ld_data_c = '0;
      case (op_q)
         OP_LW:   ld_data_c = mem_rdata;
         OP_LH:   ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         OP_LHU:  ld_data_c = {16'h0000, ld_half_c};
         OP_LB:   ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         OP_LBU:  ld_data_c = {24'h000000, ld_byte_c};
         default: ld_data_c = '0;
      endcase
   end

   // Merge the store lane into the word read back from memory
   always_comb begin
      rmw_data_c = mem_rdata;
      if (op_q == OP_SH) begin
         if (hlane_c) rmw_data_c[31:16] = wdata_q;
         else         rmw_data_c[15:0]  = wdata_q;
      end else begin
         case (blane_c)
            2'd0:    rmw_data_c[7:0]   = wdata_q[7:0];
            2'd1:    rmw_data_c[15:8]  = wdata_q[7:0];
            2'd2:    rmw_data_c[23:16] = wdata_q[7:0];
            default: rmw_data_c[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // Control FSM; mem_wdata doubles as the RMW merge register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_q       <= 3'b000;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q     <= req_op;
                  off_q    <= req_addr[1:0];
                  wdata_q  <= req_wdata[HW-1:0];
                  mem_addr <= {req_addr[31:2], 2'b00};
                  if (misaligned_c) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (is_load_c) begin
                     state <= LOAD;
                  end else if (req_op == OP_SW) begin
                     mem_wdata <= req_wdata;
                     state     <= STORE;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LOAD: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= ld_data_c;
               state      <= IDLE;
            end
            STORE: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               state      <= IDLE;
            end
            RMW_RD: begin
               mem_wdata <= rmw_data_c;
               state     <= RMW_WR;
            end
            RMW_WR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: little- and big-endian instances share the
// request stimulus, each with its own word memory model.
module tb_mem_access_unit;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        req_ready_be, resp_valid_be, resp_err_be, mem_rd_be, mem_wr_be;
   logic [31:0] resp_rdata_be, mem_addr_be, mem_wdata_be, mem_rdata_be;

   logic [31:0] mem_le [0:15];
   logic [31:0] mem_be [0:15];
   logic        pre_we;
   logic [3:0]  pre_idx;
   logic [31:0] pre_data;

   int n_total = 0;
   int n_pass  = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
   logic [31:0] last_wdata = '0;

   always #5 clk = ~clk;

   mem_access_unit #(.BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   mem_access_unit #(.BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_be),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_be), .resp_rdata(resp_rdata_be), .resp_err(resp_err_be),
      .mem_rd(mem_rd_be), .mem_wr(mem_wr_be), .mem_addr(mem_addr_be),
      .mem_wdata(mem_wdata_be), .mem_rdata(mem_rdata_be));

   assign mem_rdata    = mem_le[mem_addr[5:2]];
   assign mem_rdata_be = mem_be[mem_addr_be[5:2]];

   always @(posedge clk) begin
      if (pre_we) begin
         mem_le[pre_idx] <= pre_data;
         mem_be[pre_idx] <= pre_data;
      end else begin
         if (mem_wr)    mem_le[mem_addr[5:2]]    <= mem_wdata;
         if (mem_wr_be) mem_be[mem_addr_be[5:2]] <= mem_wdata_be;
      end
   end

   // Mid-cycle activity monitor for the little-endian instance
   always @(negedge clk) begin
      #1;
      if (mem_rd) rd_cnt++;
      if (mem_wr) begin
         wr_cnt++;
         last_wdata = mem_wdata;
      end
      if (mem_rd && mem_wr) both_cnt++;
      if (resp_valid) resp_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int drd, output int dwr);
      int rd0, wr0;
      @(negedge clk);
      rd0 = rd_cnt; wr0 = wr_cnt;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      rdata = resp_rdata; err = resp_err;
      drd = rd_cnt - rd0; dwr = wr_cnt - wr0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, drd, dwr;

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = LW; req_addr = '0; req_wdata = '0;
      pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      #3;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_memrw", {30'd0, mem_rd, mem_wr}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      preload(4'd4, 32'h8899AABB);
      preload(4'd5, 32'h01234567);
      preload(4'd0, 32'h11111111);
      preload(4'd1, 32'h22222222);
      preload(4'd2, 32'h33333333);

      do_req(LW, 32'h10, '0, rd, er, lat, drd, dwr);
      check("lw_data", rd, 32'h8899AABB);
      check("lw_err", 32'(er), 32'd0);
      check("lw_lat", 32'(lat), 32'd1);
      check("lw_rd", 32'(drd), 32'd1);
      do_req(LB, 32'h11, '0, rd, er, lat, drd, dwr);
      check("lb_data", rd, 32'hFFFFFFAA);
      do_req(LBU, 32'h11, '0, rd, er, lat, drd, dwr);
      check("lbu_data", rd, 32'h000000AA);
      do_req(LH, 32'h12, '0, rd, er, lat, drd, dwr);
      check("lh_data", rd, 32'hFFFF8899);
      do_req(LHU, 32'h10, '0, rd, er, lat, drd, dwr);
      check("lhu_data", rd, 32'h0000AABB);

      do_req(SB, 32'h13, 32'h12345677, rd, er, lat, drd, dwr);
      check("sb_lat", 32'(lat), 32'd2);
      check("sb_rd", 32'(drd), 32'd1);
      check("sb_wr", 32'(dwr), 32'd1);
      check("sb_wdata", last_wdata, 32'h7799AABB);
      check("sb_rdata", rd, 32'd0);
      do_req(LW, 32'h10, '0, rd, er, lat, drd, dwr);
      check("sb_readback", rd, 32'h7799AABB);

      preload(4'd4, 32'h8899AABB);
      do_req(SH, 32'h10, 32'hDEADBEEF, rd, er, lat, drd, dwr);
      check("sh_le_mem", mem_le[4], 32'h8899BEEF);
      check("sh_be_mem", mem_be[4], 32'hBEEFAABB);

      preload(4'd4, 32'h8899AABB);
      do_req(LW, 32'h16, '0, rd, er, lat, drd, dwr);
      check("mis_lw_err", 32'(er), 32'd1);
      check("mis_lw_data", rd, 32'd0);
      check("mis_lw_lat", 32'(lat), 32'd0);
      check("mis_lw_mem", 32'(drd + dwr), 32'd0);
      do_req(LH, 32'h13, '0, rd, er, lat, drd, dwr);
      check("mis_lh_err", 32'(er), 32'd1);
      check("mis_lh_lat", 32'(lat), 32'd0);
      check("mis_lh_mem", 32'(drd + dwr), 32'd0);
      do_req(SW, 32'h11, 32'hCAFEF00D, rd, er, lat, drd, dwr);
      check("mis_sw_err", 32'(er), 32'd1);
      check("mis_sw_data", rd, 32'd0);
      check("mis_sw_mem", 32'(drd + dwr), 32'd0);
      check("mis_word4", mem_le[4], 32'h8899AABB);
      check("mis_word5", mem_le[5], 32'h01234567);

      begin : b2b
         int acc, rsp;
         int acc_cyc [3];
         logic [31:0] rdat [3];
         logic rdy;
         acc = 0; rsp = 0;
         @(negedge clk);
         req_valid = 1'b1; req_op = LW; req_addr = 32'h0;
         for (int c = 0; c < 12; c++) begin
            rdy = req_ready;
            @(negedge clk);
            if (resp_valid) begin
               if (rsp < 3) rdat[rsp] = resp_rdata;
               rsp++;
            end
            if (rdy && req_valid) begin
               if (acc < 3) acc_cyc[acc] = c;
               acc++;
               if (acc >= 3) req_valid = 1'b0;
               else req_addr = 32'(acc * 4);
            end
         end
         req_valid = 1'b0;
         check("b2b_accepts", 32'(acc), 32'd3);
         check("b2b_resps", 32'(rsp), 32'd3);
         check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
         check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
         check("b2b_d0", rdat[0], 32'h11111111);
         check("b2b_d1", rdat[1], 32'h22222222);
         check("b2b_d2", rdat[2], 32'h33333333);
      end
      check("never_rd_wr", 32'(both_cnt), 32'd0);

      begin : rst_mid
         int r0;
         do_req(LW, 32'h10, '0, rd, er, lat, drd, dwr);
         @(negedge clk);
         req_valid = 1'b1; req_op = SB; req_addr = 32'h10; req_wdata = 32'h00000055;
         @(negedge clk);
         req_valid = 1'b0;
         @(negedge clk);
         check("rmw_wr_active", 32'(mem_wr), 32'd1);
         r0 = resp_cnt;
         reset = 1'b0;
         #1;
         check("rstm_wr", 32'(mem_wr), 32'd0);
         check("rstm_rd", 32'(mem_rd), 32'd0);
         check("rstm_ready", 32'(req_ready), 32'd1);
         check("rstm_valid", 32'(resp_valid), 32'd0);
         check("rstm_err", 32'(resp_err), 32'd0);
         check("rstm_rdata", resp_rdata, 32'd0);
         check("rstm_addr", mem_addr, 32'd0);
         check("rstm_wdata", mem_wdata, 32'd0);
         repeat (2) @(negedge clk);
         reset = 1'b1;
         repeat (3) @(negedge clk);
         check("rstm_noresp", 32'(resp_cnt - r0), 32'd0);
         check("rstm_mem", mem_le[4], 32'h8899AABB);
         do_req(LW, 32'h10, '0, rd, er, lat, drd, dwr);
         check("rstm_readback", rd, 32'h8899AABB);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
